// File: rtl/mod_addsub.sv
// mod_addsub: limb-serial modular adder/subtractor.
//   op = 0 : result = (a + b) mod M
//   op = 1 : result = (a - b) mod M
// One LIMB-wide limb is processed per cycle. The first pass (ADD) forms
// s = a +/- b, the second pass (CORR) forms t = s -/+ M, and the final
// selection picks s or t. One operation takes 2N+1 cycles including DONE.
//
// Optional feature: define MODADD_BUSY_EN to add the 'busy' output, which is
// high in ADD, CORR and DONE and low in IDLE.
//
// Handshake: 'start' is sampled only in IDLE, together with 'subtract',
// 'in_a', 'in_b' and 'in_m'. A start seen in any other state is dropped and
// has no effect. 'done' is high for exactly one cycle, while the FSM is in
// DONE, and 'result' is valid from then until the next operation's final
// selection edge. There is no back-pressure.
module mod_addsub #(
    parameter int WIDTH = 1024,
    parameter int LIMB  = 128
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
`ifdef MODADD_BUSY_EN
    ,
    output logic             busy
`endif
);

    localparam int N  = WIDTH / LIMB;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_LIMB = CW'(N - 1);

    // FSM state plus limb counter, kept together in one struct so that a
    // checker can bind to a single signal that describes the control state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        state_t          state;
        logic [CW-1:0]   cnt;
    } ctl_t;

    ctl_t r_ctl;
    ctl_t w_ctl_nxt;

    // Latched operands and working registers.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_s;      // a +/- b
    logic [WIDTH-1:0] r_t;      // s -/+ M
    logic             r_sub;    // latched operation select
    logic             r_chain;  // carry/borrow between limbs
    logic             r_c;      // final carry/borrow of the ADD pass

    // Shared limb datapath.
    logic             w_last;
    logic [BW-1:0]    w_base;
    logic             w_do_sub;
    logic [LIMB-1:0]  w_x;
    logic [LIMB-1:0]  w_y;
    logic [LIMB:0]    w_sum_ext;
    logic [LIMB-1:0]  w_limb;
    logic             w_cout;
    logic [WIDTH-1:0] w_t_full;
    logic             w_take_t;

    assign w_last = (r_ctl.cnt == LAST_LIMB);

    // Bit offset of the limb handled this cycle (LSB limb first).
    assign w_base = BW'(r_ctl.cnt) * BW'(LIMB);

    // The CORR pass runs the opposite operation of the ADD pass:
    // add mode subtracts M, subtract mode adds M back.
    assign w_do_sub = (r_ctl.state == S_CORR) ? ~r_sub : r_sub;

    // Select the limb operands: a/b during ADD, s/M during CORR.
    always_comb begin
        w_x = r_a[w_base +: LIMB];
        w_y = r_b[w_base +: LIMB];
        if (r_ctl.state == S_CORR) begin
            w_x = r_s[w_base +: LIMB];
            w_y = r_m[w_base +: LIMB];
        end
    end

    // One limb of add-with-carry or subtract-with-borrow; the extra top bit
    // is the carry out (add) or the borrow out (subtract).
    always_comb begin
        if (w_do_sub) begin
            w_sum_ext = {1'b0, w_x} - {1'b0, w_y} - {{LIMB{1'b0}}, r_chain};
        end else begin
            w_sum_ext = {1'b0, w_x} + {1'b0, w_y} + {{LIMB{1'b0}}, r_chain};
        end
    end

    assign w_limb = w_sum_ext[LIMB-1:0];
    assign w_cout = w_sum_ext[LIMB];

    // Complete t including the limb being written on this edge, so that the
    // final selection can use it in the same cycle as the last CORR limb.
    always_comb begin
        w_t_full = r_t;
        w_t_full[w_base +: LIMB] = w_limb;
    end

    // Add: t is correct when a+b overflowed WIDTH bits or s >= M (no borrow
    // out of s - M). Subtract: t is correct only when a - b borrowed.
    assign w_take_t = r_sub ? r_c : (r_c | ~w_cout);

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ctl.state <= S_IDLE;
            r_ctl.cnt   <= '0;
        end else begin
            r_ctl <= w_ctl_nxt;
        end
    end

    // Next-state and limb counter sequencing.
    always_comb begin
        w_ctl_nxt = r_ctl;
        case (r_ctl.state)
            S_IDLE: begin
                if (start) begin
                    w_ctl_nxt.state = S_ADD;
                    w_ctl_nxt.cnt   = '0;
                end
            end
            S_ADD: begin
                if (w_last) begin
                    w_ctl_nxt.state = S_CORR;
                    w_ctl_nxt.cnt   = '0;
                end else begin
                    w_ctl_nxt.cnt = r_ctl.cnt + CW'(1);
                end
            end
            S_CORR: begin
                if (w_last) begin
                    w_ctl_nxt.state = S_DONE;
                    w_ctl_nxt.cnt   = '0;
                end else begin
                    w_ctl_nxt.cnt = r_ctl.cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_ctl_nxt.state = S_IDLE;
                w_ctl_nxt.cnt   = '0;
            end
            default: begin
                w_ctl_nxt.state = S_IDLE;
                w_ctl_nxt.cnt   = '0;
            end
        endcase
    end

    // Operand capture, limb-serial accumulation and final result selection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_s     <= '0;
            r_t     <= '0;
            r_sub   <= 1'b0;
            r_chain <= 1'b0;
            r_c     <= 1'b0;
            result  <= '0;
        end else begin
            case (r_ctl.state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_m     <= in_m;
                        r_sub   <= subtract;
                        r_chain <= 1'b0;
                        r_c     <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_s[w_base +: LIMB] <= w_limb;
                    if (w_last) begin
                        // Keep the top carry/borrow as c and start CORR
                        // with a clean chain.
                        r_c     <= w_cout;
                        r_chain <= 1'b0;
                    end else begin
                        r_chain <= w_cout;
                    end
                end
                S_CORR: begin
                    r_t[w_base +: LIMB] <= w_limb;
                    r_chain             <= w_last ? 1'b0 : w_cout;
                    if (w_last) begin
                        result <= w_take_t ? w_t_full : r_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done = (r_ctl.state == S_DONE);

`ifdef MODADD_BUSY_EN
    assign busy = (r_ctl.state != S_IDLE);
`endif

endmodule

// File: tb/tb_mod_addsub.sv
// Self-checking bench for mod_addsub (default WIDTH=1024, LIMB=128, N=8).
// Expected results come from fixed vectors and from a plain-arithmetic
// modular reference model; latency, done-pulse width, result hold, reset
// abort and ignored starts are checked by hand-written sequences.
module tb_mod_addsub;

    localparam int W = 1024;
    localparam int L = 128;
    localparam int N = W / L;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         subtract;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_m;
    logic [W-1:0] result;
    logic         done;
`ifdef MODADD_BUSY_EN
    logic         busy;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;

    typedef struct {
        string        name;
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    mod_addsub #(
        .WIDTH (W),
        .LIMB  (L)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_m     (in_m),
        .result   (result),
        .done     (done)
`ifdef MODADD_BUSY_EN
        ,
        .busy     (busy)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checks ----------------
    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got top=%h low=%h, expected top=%h low=%h",
                     name, act[W-1 -: 64], act[127:0], exp[W-1 -: 64], exp[127:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_mod(input logic sub, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W:0] r;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b};
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end else if (a >= b) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge: presents one operation for one cycle, then
    // scrambles the inputs so that only the latched copy can be used.
    task automatic run_op(input string name, input logic sub, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] exp);
        int n;
        logic [W-1:0] want;
        exp_q.push_back(exp);
        start    = 1'b1;
        subtract = sub;
        in_a     = a;
        in_b     = b;
        in_m     = m;
        @(negedge clk);
        start    = 1'b0;
        subtract = ~sub;
        in_a     = ~a;
        in_b     = ~b;
        in_m     = ~m;
        n = 0;
        while (done !== 1'b1 && n < 4 * N) begin
            if (n == N) check_vec({name, " hold"}, result, last_exp);
            @(negedge clk);
            n++;
        end
        check_int({name, " latency"}, n, 2 * N);
        want = exp_q.pop_front();
        check_vec(name, result, want);
        last_exp = want;
        @(negedge clk);
        check_bit({name, " done_pulse"}, done, 1'b0);
    endtask

    // ---------------- main ----------------
    initial begin : main
        logic [W-1:0] ones;
        logic [W-1:0] p4;
        logic [W-1:0] m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        int           done_cnt;
        int           busy_cnt;

        ones = '1;
        p4   = '0;
        p4[4*L] = 1'b1;

        vecs.push_back('{"add_7_9",      1'b0, W'(7),  W'(9),    W'(13), W'(3)});
        vecs.push_back('{"sub_3_9",      1'b1, W'(3),  W'(9),    W'(13), W'(7)});
        vecs.push_back('{"sub_5_5",      1'b1, W'(5),  W'(5),    W'(13), W'(0)});
        vecs.push_back('{"add_eq_m",     1'b0, W'(4),  W'(9),    W'(13), W'(0)});
        vecs.push_back('{"add_top_c",    1'b0, ones-1, ones-1,   ones,   ones-2});
        vecs.push_back('{"add_12_12",    1'b0, W'(12), W'(12),   W'(13), W'(11)});
        vecs.push_back('{"sub_0_12",     1'b1, W'(0),  W'(12),   W'(13), W'(1)});
        vecs.push_back('{"add_zero",     1'b0, W'(0),  W'(0),    W'(13), W'(0)});
        vecs.push_back('{"sub_top_b",    1'b1, W'(0),  ones-1,   ones,   W'(1)});
        vecs.push_back('{"add_ripple",   1'b0, p4-1,   W'(1),    ones,   p4});
        vecs.push_back('{"sub_ripple",   1'b1, p4,     W'(1),    ones,   p4-1});

        resetn   = 1'b0;
        start    = 1'b0;
        subtract = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_m     = '0;
        last_exp = '0;
        repeat (3) @(negedge clk);
        check_vec("reset result", result, '0);
        check_bit("reset done", done, 1'b0);
`ifdef MODADD_BUSY_EN
        check_bit("reset busy", busy, 1'b0);
`endif

        // Release reset and start on the very first active edge.
        resetn = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 36; i++) begin
            case (i % 3)
                0:       m = rand_wide() | W'(1);
                1:       m = ones - W'($urandom_range(0, 100));
                default: m = W'($urandom_range(2, 5000));
            endcase
            a   = rand_wide() % m;
            b   = rand_wide() % m;
            sub = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), sub, a, b, m, ref_mod(sub, a, b, m));
        end

        // Start ignored while busy: the first operation's result must come back.
        start = 1'b1; subtract = 1'b0;
        in_a = W'(7); in_b = W'(9); in_m = W'(13);
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int n = 0; n < 3 * N; n++) begin
`ifdef MODADD_BUSY_EN
            if (busy === 1'b1) busy_cnt++;
`endif
            if (done === 1'b1) done_cnt++;
            if (n == 1 || n == N + 1) begin
                start = 1'b1; subtract = 1'b1;
                in_a = W'(3); in_b = W'(9); in_m = W'(11);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check_int("ignore done_count", done_cnt, 1);
        check_vec("ignore result", result, W'(3));
`ifdef MODADD_BUSY_EN
        check_int("busy cycles", busy_cnt, 2 * N + 1);
`endif
        last_exp = W'(3);

        // Reset in the middle of an operation aborts it.
        run_op("pre_abort", 1'b0, W'(100), W'(200), W'(1000), W'(300));
        start = 1'b1; subtract = 1'b0;
        in_a = W'(500); in_b = W'(600); in_m = W'(1000);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_vec("abort result", result, '0);
        check_bit("abort done", done, 1'b0);
`ifdef MODADD_BUSY_EN
        check_bit("abort busy", busy, 1'b0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 3 * N; n++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check_int("abort no_done", done_cnt, 0);
        check_vec("abort result_after", result, '0);
        last_exp = '0;
        run_op("post_abort", 1'b0, W'(7), W'(9), W'(13), W'(3));

        check_int("scoreboard empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
